// File: rtl/ad9361_tx_pkg.sv
// ad9361_tx_pkg: shared word-format constants, pattern/FSM encodings, sample type and word packer for the AD9361 TX path
package ad9361_tx_pkg;
    localparam int FRAME_BIT = 13;
    localparam int WORD_W = FRAME_BIT + 1;
    localparam int HALF_W = 6;
    localparam int SAMP_W = 12;
    localparam logic [WORD_W-1:0] IDLE_WORD = 14'h2000;
    localparam logic [1:0] PAT_STREAM = 2'b00;
    localparam logic [1:0] PAT_ZERO = 2'b01;
    localparam logic [1:0] PAT_RAMP = 2'b10;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HI = 2'd1;
    localparam logic [1:0] ST_LO = 2'd2;
    typedef struct packed {
        logic [SAMP_W-1:0] i;
        logic [SAMP_W-1:0] q;
    } iq_t;
    function automatic logic [WORD_W-1:0] pack_word(input logic frame, input logic [HALF_W-1:0] i, input logic [HALF_W-1:0] q);
        return {frame, i, 1'b0, q};
    endfunction
endpackage

// File: rtl/ad9361_tx_fifo.sv
// ad9361_tx_fifo: sync first-word-through FIFO; ports ad9361_dclk, sys_nrst, push/wr_data in, pop in, rd_data/level out
module ad9361_tx_fifo #(
    parameter int AW = 3,
    parameter int DW = 24
) (
    input  logic          ad9361_dclk,
    input  logic          sys_nrst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   level
);
    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_push = push && !level[AW];
    assign do_pop = pop && (level != '0);
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge ad9361_dclk)
        if (do_push) mem[wr_ptr] <= wr_data;
    always_ff @(posedge ad9361_dclk or negedge sys_nrst)
        if (!sys_nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
endmodule

// File: rtl/ad9361_tx_packer.sv
// ad9361_tx_packer: FIFO-buffered I/Q stream serialised to framed HI/LO words on ad9361_dout; ports tx_en, pattern_sel, clr_stats, s_valid/s_ready/s_i/s_q in, ad9361_dout, fifo_level, underflow_cnt/flag out
module ad9361_tx_packer
    import ad9361_tx_pkg::*;
#(
    parameter int FIFO_AW = 3,
    parameter int CNT_W = 16,
    parameter logic [SAMP_W-1:0] RAMP_STEP = 12'd1
) (
    input  logic               ad9361_dclk,
    input  logic               sys_nrst,
    input  logic               tx_en,
    input  logic [1:0]         pattern_sel,
    input  logic               clr_stats,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [SAMP_W-1:0]  s_i,
    input  logic [SAMP_W-1:0]  s_q,
    output logic [WORD_W-1:0]  ad9361_dout,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [CNT_W-1:0]   underflow_cnt,
    output logic               underflow_flag
);
    logic [1:0] state, nxt;
    iq_t fifo_q, held, src;
    logic [SAMP_W-1:0] ramp;
    logic enter_hi, stream, ramp_sel, pop, uf;
    assign s_ready = sys_nrst && !fifo_level[FIFO_AW];
    assign nxt = (state == ST_HI) ? ST_LO : (tx_en ? ST_HI : ST_IDLE);
    assign enter_hi = nxt == ST_HI;
    assign stream = pattern_sel == PAT_STREAM;
    assign ramp_sel = pattern_sel == PAT_RAMP;
    assign pop = enter_hi && stream && (fifo_level != '0);
    assign uf = enter_hi && stream && (fifo_level == '0);
    assign src = pop ? fifo_q : (enter_hi && ramp_sel) ? {ramp, ~ramp} : '0;
    ad9361_tx_fifo #(.AW(FIFO_AW), .DW(2 * SAMP_W)) u_fifo (
        .ad9361_dclk(ad9361_dclk),
        .sys_nrst(sys_nrst),
        .push(s_valid && s_ready),
        .pop(pop),
        .wr_data({s_i, s_q}),
        .rd_data(fifo_q),
        .level(fifo_level)
    );
    always_ff @(posedge ad9361_dclk or negedge sys_nrst)
        if (!sys_nrst) begin
            state <= ST_IDLE;
            held <= '0;
            ramp <= '0;
            ad9361_dout <= IDLE_WORD;
            underflow_cnt <= '0;
            underflow_flag <= 1'b0;
        end else begin
            state <= nxt;
            if (enter_hi) held <= src;
            if (enter_hi && ramp_sel) ramp <= ramp + RAMP_STEP;
            ad9361_dout <= enter_hi ? pack_word(1'b1, src.i[SAMP_W-1:HALF_W], src.q[SAMP_W-1:HALF_W])
                         : (nxt == ST_LO) ? pack_word(1'b0, held.i[HALF_W-1:0], held.q[HALF_W-1:0])
                         : IDLE_WORD;
            underflow_cnt <= clr_stats ? '0 : (uf && !(&underflow_cnt)) ? underflow_cnt + 1'b1 : underflow_cnt;
            underflow_flag <= clr_stats ? 1'b0 : (underflow_flag || uf);
        end
endmodule

// File: tb/tb_ad9361_tx_packer.sv
// tb_ad9361_tx_packer: scoreboard bench for ad9361_tx_packer covering reset, stream, full, underflow, latency, patterns and mid-op events
module tb_ad9361_tx_packer;
    logic ad9361_dclk = 1'b0;
    logic sys_nrst;
    logic tx_en;
    logic [1:0] pattern_sel;
    logic clr_stats;
    logic s_valid;
    logic s_ready;
    logic [11:0] s_i, s_q;
    logic [13:0] ad9361_dout;
    logic [3:0] fifo_level;
    logic [15:0] underflow_cnt;
    logic underflow_flag;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_hi = 0;
    int first_hi = -1;
    int last_hi = 0;
    bit mon_en = 1'b1;
    bit lo_pend = 1'b0;
    logic [13:0] exp_lo;
    logic [23:0] sb[$];
    logic [13:0] h, l;
    logic [11:0] r;
    ad9361_tx_packer dut (
        .ad9361_dclk(ad9361_dclk),
        .sys_nrst(sys_nrst),
        .tx_en(tx_en),
        .pattern_sel(pattern_sel),
        .clr_stats(clr_stats),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_i(s_i),
        .s_q(s_q),
        .ad9361_dout(ad9361_dout),
        .fifo_level(fifo_level),
        .underflow_cnt(underflow_cnt),
        .underflow_flag(underflow_flag)
    );
    always #5 ad9361_dclk = ~ad9361_dclk;
    function automatic logic [13:0] hi_w(input logic [23:0] s);
        return {1'b1, s[23:18], 1'b0, s[11:6]};
    endfunction
    function automatic logic [13:0] lo_w(input logic [23:0] s);
        return {1'b0, s[17:12], 1'b0, s[5:0]};
    endfunction
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    task automatic mon();
        if (!mon_en) return;
        if (lo_pend) begin
            chk("sb_lo", ad9361_dout, exp_lo);
            lo_pend = 1'b0;
        end else if (ad9361_dout[13] && ad9361_dout != 14'h2000) begin
            if (sb.size() == 0) chk("sb_empty", ad9361_dout, 14'h2000);
            else begin
                logic [23:0] s;
                s = sb.pop_front();
                chk("sb_hi", ad9361_dout, hi_w(s));
                exp_lo = lo_w(s);
                lo_pend = 1'b1;
                n_hi++;
                if (first_hi < 0) first_hi = cyc;
                last_hi = cyc;
            end
        end
    endtask
    task automatic step();
        @(negedge ad9361_dclk);
        cyc++;
        mon();
    endtask
    task automatic drive(input logic [11:0] i, input logic [11:0] q);
        s_valid = 1'b1;
        s_i = i;
        s_q = q;
        if (s_ready) sb.push_back({i, q});
    endtask
    initial begin
        sys_nrst = 1'b0;
        tx_en = 1'b0;
        pattern_sel = 2'b00;
        clr_stats = 1'b0;
        s_valid = 1'b0;
        s_i = '0;
        s_q = '0;
        repeat (2) step();
        chk("rst_dout", ad9361_dout, 14'h2000);
        chk("rst_level", fifo_level, 0);
        chk("rst_cnt", underflow_cnt, 0);
        chk("rst_flag", underflow_flag, 0);
        chk("rst_ready", s_ready, 0);
        sys_nrst = 1'b1;
        repeat (3) step();
        chk("rel_ready", s_ready, 1);
        chk("rel_dout", ad9361_dout, 14'h2000);
        // single streamed sample with loopback reconstruction
        drive(12'hABC, 12'h123);
        step();
        s_valid = 1'b0;
        chk("t2_level", fifo_level, 1);
        tx_en = 1'b1;
        step();
        h = ad9361_dout;
        tx_en = 1'b0;
        step();
        l = ad9361_dout;
        chk("t2_hi", h, 14'h3504);
        chk("t2_lo", l, 14'h1E23);
        chk("rx_i", {h[12:7], l[12:7]}, 12'hABC);
        chk("rx_q", {h[5:0], l[5:0]}, 12'h123);
        step();
        chk("t2_idle", ad9361_dout, 14'h2000);
        chk("t2_empty", fifo_level, 0);
        // fill to full while idle, then drain back-to-back
        n_hi = 0;
        first_hi = -1;
        for (int i = 0; i < 9; i++) begin
            step();
            if (i == 8) begin
                chk("full_ready", s_ready, 0);
                chk("full_level", fifo_level, 8);
            end else chk("fill_ready", s_ready, 1);
            drive(12'h840 + 12'(i * 'h111), 12'h5A5 ^ 12'(i));
        end
        step();
        s_valid = 1'b0;
        chk("full_hold", fifo_level, 8);
        chk("full_sb", sb.size(), 8);
        tx_en = 1'b1;
        repeat (15) step();
        tx_en = 1'b0;
        repeat (2) step();
        chk("drain_n", n_hi, 8);
        chk("drain_span", last_hi - first_hi, 14);
        chk("drain_sb", sb.size(), 0);
        chk("drain_level", fifo_level, 0);
        chk("drain_idle", ad9361_dout, 14'h2000);
        chk("drain_nouf", underflow_cnt, 0);
        // underflow counting and clear-wins
        step();
        tx_en = 1'b1;
        for (int u = 1; u <= 3; u++) begin
            step();
            chk("uf_hi", ad9361_dout, 14'h2000);
            chk("uf_cnt", underflow_cnt, u);
            step();
            chk("uf_lo", ad9361_dout, 14'h0000);
        end
        chk("uf_flag", underflow_flag, 1);
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        chk("clr_cnt", underflow_cnt, 0);
        chk("clr_flag", underflow_flag, 0);
        chk("clr_dout", ad9361_dout, 14'h2000);
        tx_en = 1'b0;
        repeat (2) step();
        chk("uf_idle_cnt", underflow_cnt, 0);
        // push while in HI lands in FIFO as FSM enters LO, sent on the next HI
        step();
        tx_en = 1'b1;
        step();
        chk("lat_uf", ad9361_dout, 14'h2000);
        drive(12'h7C1, 12'hF0E);
        step();
        s_valid = 1'b0;
        chk("lat_lo", ad9361_dout, 14'h0000);
        chk("lat_level", fifo_level, 1);
        step();
        chk("lat_hi", ad9361_dout, hi_w({12'h7C1, 12'hF0E}));
        tx_en = 1'b0;
        repeat (2) step();
        chk("lat_idle", ad9361_dout, 14'h2000);
        chk("lat_cnt", underflow_cnt, 1);
        chk("lat_flag", underflow_flag, 1);
        // zero pattern leaves FIFO untouched
        step();
        s_valid = 1'b1;
        s_i = 12'h9A5;
        s_q = 12'h3C7;
        step();
        s_valid = 1'b0;
        pattern_sel = 2'b01;
        tx_en = 1'b1;
        step();
        chk("zero_hi", ad9361_dout, 14'h2000);
        tx_en = 1'b0;
        step();
        chk("zero_lo", ad9361_dout, 14'h0000);
        step();
        chk("zero_level", fifo_level, 1);
        chk("zero_cnt", underflow_cnt, 1);
        // tx_en drop and pattern change during HI
        pattern_sel = 2'b00;
        sb.push_back({12'h9A5, 12'h3C7});
        tx_en = 1'b1;
        step();
        tx_en = 1'b0;
        pattern_sel = 2'b10;
        step();
        step();
        chk("mid_idle", ad9361_dout, 14'h2000);
        chk("mid_level", fifo_level, 0);
        chk("mid_sb", sb.size(), 0);
        // ramp pattern across the 12-bit wrap
        mon_en = 1'b0;
        tx_en = 1'b1;
        for (int s = 0; s < 4098; s++) begin
            r = 12'(s);
            step();
            chk("ramp_hi", ad9361_dout, hi_w({r, ~r}));
            if (s == 4097) tx_en = 1'b0;
            step();
            chk("ramp_lo", ad9361_dout, lo_w({r, ~r}));
        end
        step();
        chk("ramp_idle", ad9361_dout, 14'h2000);
        // async reset while in LO
        mon_en = 1'b1;
        pattern_sel = 2'b00;
        step();
        drive(12'hD2B, 12'h4E6);
        step();
        drive(12'h6F1, 12'hB38);
        step();
        s_valid = 1'b0;
        tx_en = 1'b1;
        step();
        step();
        #2 sys_nrst = 1'b0;
        #1;
        chk("nrst_dout", ad9361_dout, 14'h2000);
        chk("nrst_level", fifo_level, 0);
        chk("nrst_ready", s_ready, 0);
        chk("nrst_cnt", underflow_cnt, 0);
        chk("nrst_flag", underflow_flag, 0);
        tx_en = 1'b0;
        sb.delete();
        lo_pend = 1'b0;
        repeat (2) step();
        sys_nrst = 1'b1;
        repeat (2) step();
        chk("end_ready", s_ready, 1);
        chk("end_dout", ad9361_dout, 14'h2000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
